// File: rtl/posit_mac_seq_pkg.sv
// Shared types and width helpers for the posit MAC sequencer.
package posit_mac_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FEED = 3'd1,
      S_WAIT = 3'd2,
      S_OUT  = 3'd3,
      S_FIN  = 3'd4
   } state_e;

   localparam int K_DEF       = 9;
   localparam int TIMEOUT_DEF = 32;
   localparam int WK          = $clog2(K_DEF);
   localparam int TW          = $clog2(TIMEOUT_DEF + 1);

   function automatic int k_w(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

   function automatic int tmo_w(input int t);
      return $clog2(t + 1);
   endfunction

endpackage

// File: rtl/posit_mac_addr_gen.sv
// k/j counters and SRAM address generation; the per-output data base is
// accumulated by adding the stride, so no multiplier is needed.
module posit_mac_addr_gen
   import posit_mac_seq_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int K      = 9,
   parameter int KW     = k_w(K)
) (
   input  logic              clk_i,
   input  logic              rstn,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] w_base_i,
   input  logic [ADDR_W-1:0] d_base_i,
   input  logic [ADDR_W-1:0] d_stride_i,
   input  logic              k_step_i,
   input  logic              k_clr_i,
   input  logic              j_step_i,
   output logic              k_last_o,
   output logic [ADDR_W-1:0] j_o,
   output logic [ADDR_W-1:0] w_addr_o,
   output logic [ADDR_W-1:0] d_addr_o
);

   logic [KW-1:0]     k_q, k_d;
   logic [ADDR_W-1:0] j_q, j_d;
   logic [ADDR_W-1:0] w_base_q, w_base_d;
   logic [ADDR_W-1:0] d_cur_q, d_cur_d;
   logic [ADDR_W-1:0] stride_q, stride_d;

   always_comb begin
      k_d      = k_q;
      j_d      = j_q;
      w_base_d = w_base_q;
      d_cur_d  = d_cur_q;
      stride_d = stride_q;
      if (load_i) begin
         k_d      = '0;
         j_d      = '0;
         w_base_d = w_base_i;
         d_cur_d  = d_base_i;
         stride_d = d_stride_i;
      end else begin
         if (k_clr_i)       k_d = '0;
         else if (k_step_i) k_d = k_q + 1'b1;
         if (j_step_i) begin
            j_d     = j_q + 1'b1;
            d_cur_d = d_cur_q + stride_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn) begin
         k_q      <= '0;
         j_q      <= '0;
         w_base_q <= '0;
         d_cur_q  <= '0;
         stride_q <= '0;
      end else begin
         k_q      <= k_d;
         j_q      <= j_d;
         w_base_q <= w_base_d;
         d_cur_q  <= d_cur_d;
         stride_q <= stride_d;
      end
   end

   assign k_last_o = (k_q == KW'(K - 1));
   assign j_o      = j_q;
   assign w_addr_o = w_base_q + ADDR_W'(k_q);
   assign d_addr_o = d_cur_q + ADDR_W'(k_q);

endmodule

// File: rtl/posit_mac_seq.sv
// Sequencer feeding one posit MAC from weight/activation SRAMs, one output
// in flight at a time, results handed downstream over valid/ready.
//
//   state  | meaning
//   IDLE   | waiting for start_i
//   FEED   | issuing K SRAM reads for output j
//   WAIT   | waiting for MAC result, timeout down-counter running
//   OUT    | result presented until consumer handshake
//   FIN    | done_o pulse, back to IDLE
module posit_mac_seq
   import posit_mac_seq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int K       = 9,
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 32
) (
   input  logic              clk_i,
   input  logic              rstn,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] n_out_i,
   input  logic [ADDR_W-1:0] w_base_i,
   input  logic [ADDR_W-1:0] d_base_i,
   input  logic [ADDR_W-1:0] d_stride_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_timeout_o,
   output logic              w_re_o,
   output logic [ADDR_W-1:0] w_addr_o,
   input  logic [WIDTH-1:0]  w_rdata_i,
   output logic              d_re_o,
   output logic [ADDR_W-1:0] d_addr_o,
   input  logic [WIDTH-1:0]  d_rdata_i,
   output logic              mac_vld_o,
   output logic [WIDTH-1:0]  mac_win_o,
   output logic [WIDTH-1:0]  mac_din_o,
   input  logic [WIDTH-1:0]  mac_acc_i,
   input  logic              mac_vld_i,
   output logic              res_vld_o,
   output logic [WIDTH-1:0]  res_data_o,
   output logic [ADDR_W-1:0] res_idx_o,
   input  logic              res_rdy_i
);

   localparam int TMW = tmo_w(TIMEOUT);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] n_out_q, n_out_d;
   logic [TMW-1:0]    tmo_q, tmo_d;
   logic              err_q, err_d;
   logic              mac_vld_q, mac_vld_d;
   logic [WIDTH-1:0]  res_data_q, res_data_d;
   logic [ADDR_W-1:0] res_idx_q, res_idx_d;

   logic              load, k_step, k_clr, j_step, k_last;
   logic [ADDR_W-1:0] j_cur, w_addr, d_addr;

   posit_mac_addr_gen #(
      .ADDR_W (ADDR_W),
      .K      (K)
   ) u_addr_gen (
      .clk_i      (clk_i),
      .rstn       (rstn),
      .load_i     (load),
      .w_base_i   (w_base_i),
      .d_base_i   (d_base_i),
      .d_stride_i (d_stride_i),
      .k_step_i   (k_step),
      .k_clr_i    (k_clr),
      .j_step_i   (j_step),
      .k_last_o   (k_last),
      .j_o        (j_cur),
      .w_addr_o   (w_addr),
      .d_addr_o   (d_addr)
   );

   always_comb begin
      state_d    = state_q;
      n_out_d    = n_out_q;
      tmo_d      = tmo_q;
      err_d      = err_q;
      res_data_d = res_data_q;
      res_idx_d  = res_idx_q;
      mac_vld_d  = (state_q == S_FEED);
      load       = 1'b0;
      k_step     = 1'b0;
      k_clr      = 1'b0;
      j_step     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               load    = 1'b1;
               n_out_d = n_out_i;
               err_d   = 1'b0;
               state_d = (n_out_i == '0) ? S_FIN : S_FEED;
            end
         end
         S_FEED: begin
            if (k_last) begin
               k_clr   = 1'b1;
               tmo_d   = TMW'(TIMEOUT);
               state_d = S_WAIT;
            end else begin
               k_step = 1'b1;
            end
         end
         // A result arriving on the terminal-count cycle still wins.
         S_WAIT: begin
            if (mac_vld_i) begin
               res_data_d = mac_acc_i;
               res_idx_d  = j_cur;
               state_d    = S_OUT;
            end else if (tmo_q == TMW'(1)) begin
               err_d   = 1'b1;
               state_d = S_FIN;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         S_OUT: begin
            if (res_rdy_i) begin
               if (j_cur + ADDR_W'(1) == n_out_q) begin
                  state_d = S_FIN;
               end else begin
                  j_step  = 1'b1;
                  state_d = S_FEED;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         n_out_q    <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         mac_vld_q  <= 1'b0;
         res_data_q <= '0;
         res_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         n_out_q    <= n_out_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
         mac_vld_q  <= mac_vld_d;
         res_data_q <= res_data_d;
         res_idx_q  <= res_idx_d;
      end
   end

   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_FIN);
   assign err_timeout_o = err_q;
   assign w_re_o        = (state_q == S_FEED);
   assign d_re_o        = (state_q == S_FEED);
   assign w_addr_o      = w_re_o ? w_addr : '0;
   assign d_addr_o      = d_re_o ? d_addr : '0;
   assign mac_vld_o     = mac_vld_q;
   assign mac_win_o     = mac_vld_q ? w_rdata_i : '0;
   assign mac_din_o     = mac_vld_q ? d_rdata_i : '0;
   assign res_vld_o     = (state_q == S_OUT);
   assign res_data_o    = res_data_q;
   assign res_idx_o     = res_idx_q;

endmodule

// File: tb/tb_posit_mac_seq.sv
// Scoreboard bench for posit_mac_seq with SRAM and latency-13 MAC stand-ins.
module tb_posit_mac_seq;

   localparam int WIDTH   = 8;
   localparam int K       = 9;
   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 32;
   localparam int MAC_LAT = 13;

   logic              clk_i = 1'b0;
   logic              rstn = 1'b0;
   logic              start_i = 1'b0;
   logic [ADDR_W-1:0] n_out_i = '0;
   logic [ADDR_W-1:0] w_base_i = '0;
   logic [ADDR_W-1:0] d_base_i = '0;
   logic [ADDR_W-1:0] d_stride_i = '0;
   logic              busy_o, done_o, err_timeout_o;
   logic              w_re_o, d_re_o;
   logic [ADDR_W-1:0] w_addr_o, d_addr_o;
   logic [WIDTH-1:0]  w_rdata_i = '0;
   logic [WIDTH-1:0]  d_rdata_i = '0;
   logic              mac_vld_o;
   logic [WIDTH-1:0]  mac_win_o, mac_din_o;
   logic [WIDTH-1:0]  mac_acc_i = '0;
   logic              mac_vld_i = 1'b0;
   logic              res_vld_o;
   logic [WIDTH-1:0]  res_data_o;
   logic [ADDR_W-1:0] res_idx_o;
   logic              res_rdy_i = 1'b1;

   posit_mac_seq #(
      .WIDTH (WIDTH), .K (K), .ADDR_W (ADDR_W), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i (clk_i), .rstn (rstn), .start_i (start_i), .n_out_i (n_out_i),
      .w_base_i (w_base_i), .d_base_i (d_base_i), .d_stride_i (d_stride_i),
      .busy_o (busy_o), .done_o (done_o), .err_timeout_o (err_timeout_o),
      .w_re_o (w_re_o), .w_addr_o (w_addr_o), .w_rdata_i (w_rdata_i),
      .d_re_o (d_re_o), .d_addr_o (d_addr_o), .d_rdata_i (d_rdata_i),
      .mac_vld_o (mac_vld_o), .mac_win_o (mac_win_o), .mac_din_o (mac_din_o),
      .mac_acc_i (mac_acc_i), .mac_vld_i (mac_vld_i),
      .res_vld_o (res_vld_o), .res_data_o (res_data_o), .res_idx_o (res_idx_o),
      .res_rdy_i (res_rdy_i)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected event (t=%0t)", name, $time);
   endtask

   // SRAM stand-ins
   logic [WIDTH-1:0] w_mem [1024];
   logic [WIDTH-1:0] d_mem [1024];

   initial begin
      for (int i = 0; i < 1024; i++) begin
         w_mem[i] = 8'((i * 7) + 3);
         d_mem[i] = 8'(i ^ (i >> 3) ^ 8'h5A);
      end
   end

   always @(posedge clk_i) begin
      if (w_re_o) w_rdata_i <= w_mem[w_addr_o];
      if (d_re_o) d_rdata_i <= d_mem[d_addr_o];
   end

   // MAC stand-in: order-sensitive combine, result MAC_LAT cycles after the K-th input
   bit               mac_en = 1'b1;
   logic [WIDTH-1:0] m_acc = '0;
   logic [WIDTH-1:0] m_res = '0;
   int               m_cnt = 0;
   int               m_dly = 0;

   always @(posedge clk_i) begin
      mac_vld_i <= 1'b0;
      if (!rstn) begin
         m_acc <= '0;
         m_cnt <= 0;
         m_dly <= 0;
      end else begin
         if (mac_vld_o) begin
            if (m_cnt == K - 1) begin
               m_cnt <= 0;
               m_acc <= '0;
               m_res <= m_acc * 8'd3 + (mac_win_o ^ mac_din_o);
               m_dly <= MAC_LAT;
            end else begin
               m_cnt <= m_cnt + 1;
               m_acc <= m_acc * 8'd3 + (mac_win_o ^ mac_din_o);
            end
         end
         if (m_dly != 0) begin
            m_dly <= m_dly - 1;
            if (m_dly == 1 && mac_en) begin
               mac_vld_i <= 1'b1;
               mac_acc_i <= m_res;
            end
         end
      end
   end

   function automatic int exp_res(input int wb, input int db, input int ds, input int j);
      logic [WIDTH-1:0] acc;
      acc = '0;
      for (int k = 0; k < K; k++)
         acc = acc * 8'd3 + (w_mem[(wb + k) & 1023] ^ d_mem[(db + j * ds + k) & 1023]);
      return int'(acc);
   endfunction

   typedef struct { int w; int d; } addr_t;
   typedef struct { int data; int idx; } res_t;
   addr_t addr_q[$];
   res_t  res_q[$];

   int done_cnt = 0;
   int rd_cnt   = 0;
   int mac_cnt  = 0;
   int res_cnt  = 0;
   int run_len  = 0;
   addr_t ma;
   res_t  mr;

   // Monitor: pops scoreboard entries whenever the DUT presents a read or a result
   always @(negedge clk_i) begin
      if (!rstn) begin
         run_len = 0;
      end else begin
         if (done_o) done_cnt++;
         if (w_re_o || d_re_o) begin
            rd_cnt++;
            check("re_pair", d_re_o, w_re_o);
            if (addr_q.size() == 0) fail_now("addr_extra");
            else begin
               ma = addr_q.pop_front();
               check("w_addr", w_addr_o, ma.w);
               check("d_addr", d_addr_o, ma.d);
            end
         end
         if (mac_vld_o) begin
            mac_cnt++;
            run_len++;
         end else if (run_len != 0) begin
            check("mac_run", run_len, K);
            run_len = 0;
         end
         if (res_vld_o && res_rdy_i) begin
            res_cnt++;
            if (res_q.size() == 0) fail_now("res_extra");
            else begin
               mr = res_q.pop_front();
               check("res_data", res_data_o, mr.data);
               check("res_idx", res_idx_o, mr.idx);
            end
         end
      end
   end

   task automatic start_job(input int n, input int wb, input int db, input int ds, input bit push_res);
      addr_t a;
      res_t  r;
      for (int j = 0; j < n; j++) begin
         for (int k = 0; k < K; k++) begin
            a.w = (wb + k) & 1023;
            a.d = (db + j * ds + k) & 1023;
            addr_q.push_back(a);
         end
         if (push_res) begin
            r.data = exp_res(wb, db, ds, j);
            r.idx  = j;
            res_q.push_back(r);
         end
      end
      done_cnt = 0;
      rd_cnt   = 0;
      mac_cnt  = 0;
      res_cnt  = 0;
      @(posedge clk_i); #1;
      n_out_i    = ADDR_W'(n);
      w_base_i   = ADDR_W'(wb);
      d_base_i   = ADDR_W'(db);
      d_stride_i = ADDR_W'(ds);
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk_i);
         if (done_o) seen = 1'b1;
      end
      if (!seen) fail_now({name, "_done_timeout"});
      @(negedge clk_i);
      check({name, "_busy_after"}, busy_o, 0);
      check({name, "_done_cnt"}, done_cnt, 1);
      check({name, "_addr_left"}, addr_q.size(), 0);
      check({name, "_res_left"}, res_q.size(), 0);
   endtask

   task automatic wait_sig_res_vld(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk_i);
         if (res_vld_o) seen = 1'b1;
      end
      if (!seen) fail_now({name, "_res_vld_timeout"});
   endtask

   task automatic check_idle_zero(input string name);
      check({name, "_busy"}, busy_o, 0);
      check({name, "_done"}, done_o, 0);
      check({name, "_err"}, err_timeout_o, 0);
      check({name, "_w_re"}, w_re_o, 0);
      check({name, "_d_re"}, d_re_o, 0);
      check({name, "_w_addr"}, w_addr_o, 0);
      check({name, "_d_addr"}, d_addr_o, 0);
      check({name, "_mac_vld"}, mac_vld_o, 0);
      check({name, "_mac_win"}, mac_win_o, 0);
      check({name, "_res_vld"}, res_vld_o, 0);
      check({name, "_res_data"}, res_data_o, 0);
      check({name, "_res_idx"}, res_idx_o, 0);
   endtask

   logic [WIDTH-1:0]  cap_d;
   logic [ADDR_W-1:0] cap_i;

   initial begin
      int c;
      bit seen;

      // Reset
      rstn = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rstn = 1'b1;
      @(negedge clk_i);
      check_idle_zero("reset");

      // Basic job
      start_job(2, 0, 100, 9, 1'b1);
      wait_done("basic");
      check("basic_mac_pulses", mac_cnt, 18);
      check("basic_res_cnt", res_cnt, 2);

      // Backpressure
      res_rdy_i = 1'b0;
      start_job(2, 50, 200, 5, 1'b1);
      wait_sig_res_vld("bp");
      cap_d = res_data_o;
      cap_i = res_idx_o;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk_i);
         check("bp_data_stable", res_data_o, cap_d);
         check("bp_idx_stable", res_idx_o, cap_i);
         check("bp_vld_held", res_vld_o, 1);
         check("bp_no_read", w_re_o, 0);
      end
      @(posedge clk_i); #1 res_rdy_i = 1'b1;
      @(negedge clk_i);
      check("bp_no_read_at_hs", w_re_o, 0);
      @(negedge clk_i);
      check("bp_feed_after_hs", w_re_o, 1);
      wait_done("bp");
      check("bp_res_cnt", res_cnt, 2);

      // Timeout
      mac_en = 1'b0;
      start_job(1, 7, 33, 1, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk_i);
         if (!w_re_o && busy_o) seen = 1'b1;
      end
      if (!seen) fail_now("tmo_wait_entry");
      c = 0;
      seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk_i);
         if (err_timeout_o) begin
            seen = 1'b1;
            c = i;
         end
      end
      check("tmo_cycles", c, TIMEOUT);
      check("tmo_done", done_o, 1);
      @(negedge clk_i);
      check("tmo_idle", busy_o, 0);
      check("tmo_err_sticky", err_timeout_o, 1);
      check("tmo_no_result", res_cnt, 0);
      check("tmo_done_cnt", done_cnt, 1);
      mac_en = 1'b1;
      repeat (20) @(negedge clk_i);
      start_job(1, 12, 40, 3, 1'b1);
      @(negedge clk_i);
      check("tmo_err_cleared", err_timeout_o, 0);
      wait_done("after_tmo");

      // n_out = 0
      start_job(0, 5, 5, 5, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 3 && !seen; i++) begin
         @(negedge clk_i);
         if (done_o) seen = 1'b1;
      end
      check("n0_done_seen", seen, 1);
      repeat (3) @(negedge clk_i);
      check("n0_done_cnt", done_cnt, 1);
      check("n0_no_reads", rd_cnt, 0);
      check("n0_idle", busy_o, 0);

      // start_i during FEED is ignored
      start_job(1, 10, 300, 7, 1'b1);
      @(posedge clk_i); #1;
      n_out_i    = 10'd5;
      w_base_i   = 10'd0;
      d_base_i   = 10'd0;
      d_stride_i = 10'd1;
      start_i    = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
      wait_done("start_in_feed");
      check("sif_mac_pulses", mac_cnt, 9);
      check("sif_res_cnt", res_cnt, 1);

      // Address wrap
      start_job(1, 3, 1020, 9, 1'b1);
      wait_done("wrap");

      // Reset during k=4 of FEED
      start_job(2, 20, 400, 11, 1'b1);
      c = 0;
      for (int i = 0; i < 50 && c < 4; i++) begin
         @(negedge clk_i);
         if (w_re_o) c++;
      end
      check("rst_reached_k3", c, 4);
      @(posedge clk_i); #1;
      rstn = 1'b0;
      addr_q.delete();
      res_q.delete();
      @(posedge clk_i); #1;
      rstn = 1'b1;
      @(negedge clk_i);
      check_idle_zero("midrst");
      repeat (25) @(negedge clk_i);
      check("midrst_no_done", done_cnt, 0);
      check("midrst_no_res", res_cnt, 0);
      start_job(2, 30, 500, 13, 1'b1);
      wait_done("post_rst");
      check("post_rst_res_cnt", res_cnt, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
